// File: rtl/rca_seq_ctrl_if.sv
// Operand/result handshake bundle for rca_seq_ctrl.
// slave is the controller side; master is the upstream/downstream side.
interface rca_seq_ctrl_if #(
  parameter int unsigned N = 4
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_a;
  logic [N-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_sum;
  logic         out_cout;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_sum, out_cout
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_sum, out_cout
  );
endinterface

// File: rtl/rca_seq_ctrl.sv
// Sequential launch/settle/capture controller around an external N-bit ripple-carry adder.
// Optional RCA_SEQ_SAT_EN: saturate the captured sum to all-ones when the adder carries out.
module rca_seq_ctrl #(
  parameter int unsigned N      = 4,
  parameter int unsigned SETTLE = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  rca_seq_ctrl_if.slave io,
  output logic [N-1:0] add_a,
  output logic [N-1:0] add_b,
  input  logic [N-1:0] add_s,
  input  logic         add_cout,
  output logic         busy
);

  if (SETTLE < 1 || SETTLE > 255) begin : g_bad_settle
    $error("rca_seq_ctrl: SETTLE must be in 1..255");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_DONE
  } state_t;

  state_t     state;
  logic [7:0] cnt;

  // DONE can hand off to a new pair on the same edge the result is taken.
  assign io.in_ready = (state == S_IDLE) || ((state == S_DONE) && io.out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      cnt          <= '0;
      add_a        <= '0;
      add_b        <= '0;
      io.out_sum   <= '0;
      io.out_cout  <= 1'b0;
      io.out_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (io.in_valid) begin
            add_a <= io.in_a;
            add_b <= io.in_b;
            cnt   <= 8'(SETTLE);
            busy  <= 1'b1;
            state <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (cnt == 8'd1) begin
`ifdef RCA_SEQ_SAT_EN
            io.out_sum <= add_cout ? '1 : add_s;
`else
            io.out_sum <= add_s;
`endif
            io.out_cout  <= add_cout;
            io.out_valid <= 1'b1;
            state        <= S_DONE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        S_DONE: begin
          if (io.out_ready) begin
            io.out_valid <= 1'b0;
            if (io.in_valid) begin
              add_a <= io.in_a;
              add_b <= io.in_b;
              cnt   <= 8'(SETTLE);
              state <= S_SETTLE;
            end else begin
              busy  <= 1'b0;
              state <= S_IDLE;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
